// File: rtl/trojan_vector_sweeper.sv
// Exhaustive stimulus/response sweeper with valid/ready record stream and MISR signature.
// Define SWEEP_LFSR_EN to visit vectors as 0 followed by a maximal LFSR sequence instead of a binary count.
module trojan_vector_sweeper #(
  parameter int                IN_W       = 2,
  parameter int                OUT_W      = 1,
  parameter int                SETTLE_CYC = 1,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h002D,
  parameter logic [MISR_W-1:0] MISR_SEED  = 16'hFFFF
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [IN_W-1:0]   rec_vec,
  output logic [OUT_W-1:0]  rec_resp,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [IN_W:0]     vec_count
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_HOLD, S_DONE} state_e;

  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);
  localparam logic [IN_W:0] LAST_IDX = {1'b0, {IN_W{1'b1}}};

`ifdef SWEEP_LFSR_EN
  // Feedback taps (bit positions XORed with the MSB) giving a maximal-length sequence.
  function automatic logic [7:0] tap_mask(input int w);
    case (w)
      2:       return 8'h01;
      3:       return 8'h02;
      4:       return 8'h04;
      5:       return 8'h04;
      6:       return 8'h10;
      7:       return 8'h20;
      8:       return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction
  localparam logic [IN_W-1:0] TAP_MASK = IN_W'(tap_mask(IN_W));
`endif

  function automatic logic [IN_W-1:0] next_vec(input logic [IN_W-1:0] v);
`ifdef SWEEP_LFSR_EN
    if (IN_W >= 2 && IN_W <= 8) begin
      if (v == '0) return IN_W'(1);
      return (v << 1) | IN_W'(v[IN_W-1] ^ (^(v & TAP_MASK)));
    end
`endif
    return v + IN_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [IN_W:0]      idx_q, idx_d;
  logic [IN_W-1:0]    vec_q, vec_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rec_valid_q, rec_valid_d;
  logic [IN_W-1:0]    rec_vec_q, rec_vec_d;
  logic [OUT_W-1:0]   rec_resp_q, rec_resp_d;
  logic [MISR_W-1:0]  sig_q, sig_d;
  logic [IN_W:0]      count_q, count_d;
  logic               accept;
  logic               last_vec;

  assign accept   = rec_valid_q & rec_ready;
  assign last_vec = (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_APPLY;
        S_APPLY:        state_d = S_SETTLE;
        S_SETTLE:       if (cnt_q == 8'd1) state_d = S_HOLD;
        S_HOLD:         if (accept) state_d = last_vec ? S_DONE : S_APPLY;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_HOLD);
    done = (state_q == S_DONE);
  end

  // Datapath: everything holds unless the current state says otherwise.
  always_comb begin
    idx_d       = idx_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    rec_valid_d = rec_valid_q;
    rec_vec_d   = rec_vec_q;
    rec_resp_d  = rec_resp_q;
    sig_d       = sig_q;
    count_d     = count_q;
    if (abort) begin
      rec_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_d       = '0;
            vec_d       = '0;
            sig_d       = MISR_SEED;
            count_d     = '0;
            rec_valid_d = 1'b0;
          end
        end
        S_APPLY: cnt_d = SETTLE_LD;
        S_SETTLE: begin
          if (cnt_q == 8'd1) begin
            rec_resp_d  = dut_out;
            rec_vec_d   = vec_q;
            rec_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_HOLD: begin
          if (accept) begin
            rec_valid_d = 1'b0;
            count_d     = count_q + 1'b1;
            sig_d       = {sig_q[MISR_W-2:0], 1'b0}
                        ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                        ^ MISR_W'(rec_resp_q);
            if (!last_vec) begin
              idx_d = idx_q + 1'b1;
              vec_d = next_vec(vec_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= '0;
      rec_resp_q  <= '0;
      sig_q       <= MISR_SEED;
      count_q     <= '0;
    end else begin
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      rec_valid_q <= rec_valid_d;
      rec_vec_q   <= rec_vec_d;
      rec_resp_q  <= rec_resp_d;
      sig_q       <= sig_d;
      count_q     <= count_d;
    end
  end

  assign dut_in    = vec_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec   = rec_vec_q;
  assign rec_resp  = rec_resp_q;
  assign signature = sig_q;
  assign vec_count = count_q;

endmodule

// File: tb/tb_trojan_vector_sweeper.sv
// Randomised self-checking bench for trojan_vector_sweeper against a record-level sweep model.
module tb_trojan_vector_sweeper;

  localparam int IN_W  = 2;
  localparam int OUT_W = 1;
`ifdef SWEEP_LFSR_EN
  localparam int SETTLE = 3;
  localparam logic [15:0] GOLD_XOR = 16'hFE5E;
`else
  localparam int SETTLE = 1;
  localparam logic [15:0] GOLD_XOR = 16'hFE5D;
`endif
  localparam logic [15:0] GOLD_ZERO  = 16'hFE5B;
  localparam logic [15:0] GOLD_ABORT = 16'hFF8A;
  localparam int NVEC   = 1 << IN_W;
  localparam int BUDGET = NVEC * (SETTLE + 2) * 20 + 50;

  logic              CK = 1'b0;
  logic              reset, start, abort, rec_ready;
  logic [IN_W-1:0]   dut_in, rec_vec;
  logic [OUT_W-1:0]  dut_out, rec_resp;
  logic              rec_valid, busy, done;
  logic [15:0]       signature;
  logic [IN_W:0]     vec_count;
  logic [OUT_W-1:0]  resp_tab [NVEC];

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  // The benchmark under test is a lookup table indexed by the applied vector.
  assign dut_out = resp_tab[dut_in];

  trojan_vector_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE)) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_vec(rec_vec), .rec_resp(rec_resp),
    .busy(busy), .done(done), .signature(signature), .vec_count(vec_count)
  );

  // k-th vector of the sweep order.
  function automatic logic [IN_W-1:0] exp_vec(input int k);
`ifdef SWEEP_LFSR_EN
    logic [IN_W-1:0] s;
    if (k == 0) return '0;
    s = IN_W'(1);
    for (int j = 1; j < k; j++) s = {s[IN_W-2:0], s[IN_W-1] ^ s[0]};
    return s;
`else
    return IN_W'(k);
`endif
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [OUT_W-1:0] r);
    logic [15:0] n;
    n = 16'((32'(s) * 2) % 65536);
    if (s >= 16'h8000) n = n ^ 16'h002D;
    return n ^ 16'(r);
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic fill_xor();
    for (int v = 0; v < NVEC; v++) resp_tab[v] = OUT_W'(v[0] ^ v[1]);
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles on record index 1.
  // abort_at >= 0 aborts (with start) while record abort_at is being held.
  task automatic run_sweep(input string name, input int mode, input int abort_at,
                           input logic [15:0] golden, input bit use_golden);
    int k = 0;
    int c = 0;
    int stall = 0;
    bit acc;
    bit seen = 0;
    bit prev_stalled = 0;
    logic [15:0] msig = 16'hFFFF;
    logic [IN_W-1:0] pv;
    logic [OUT_W-1:0] pr;
    logic [IN_W-1:0] ev;

    start = 1'b1;
    rec_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dut_in !== exp_vec(0)) begin
      errors++;
      $display("FAIL %s start: busy=%b dut_in=%h, required busy=1 dut_in=%h", name, busy, dut_in, exp_vec(0));
    end
    checks++;
    if (signature !== 16'hFFFF || vec_count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s start-state: sig=%h cnt=%0d done=%b, required FFFF/0/0", name, signature, vec_count, done);
    end

    while (!done && c < BUDGET) begin
      if (prev_stalled) begin
        checks++;
        if (rec_valid !== 1'b1 || rec_vec !== pv || rec_resp !== pr) begin
          errors++;
          $display("FAIL %s stall-hold: valid=%b vec=%h resp=%h, required 1/%h/%h", name, rec_valid, rec_vec, rec_resp, pv, pr);
        end
      end
      if (rec_valid) begin
        ev = exp_vec(k);
        if (!seen && mode == 0 && k == 0) begin
          checks++;
          if (c != SETTLE + 1) begin
            errors++;
            $display("FAIL %s first-valid: cycle %0d, required %0d", name, c, SETTLE + 1);
          end
        end
        seen = 1;
        checks++;
        if (rec_vec !== ev || rec_resp !== resp_tab[ev] || dut_in !== ev) begin
          errors++;
          $display("FAIL %s rec%0d: vec=%h resp=%h dut_in=%h, required vec=%h resp=%h", name, k, rec_vec, rec_resp, dut_in, ev, resp_tab[ev]);
        end
        if (k == abort_at) begin
          abort = 1'b1;
          start = 1'b1;
          rec_ready = 1'b1;
          tick();
          abort = 1'b0;
          start = 1'b0;
          checks++;
          if (busy !== 1'b0 || done !== 1'b0 || rec_valid !== 1'b0 || vec_count !== (IN_W+1)'(k) || signature !== msig) begin
            errors++;
            $display("FAIL %s abort: busy=%b done=%b valid=%b cnt=%0d sig=%h, required 0/0/0/%0d/%h", name, busy, done, rec_valid, vec_count, signature, k, msig);
          end
          if (use_golden) begin
            checks++;
            if (signature !== golden) begin
              errors++;
              $display("FAIL %s abort-sig: got %h, required %h", name, signature, golden);
            end
          end
          return;
        end
      end
      case (mode)
        1:       rec_ready = 1'($urandom_range(0, 1));
        2:       if (rec_valid && k == 1 && stall < 5) begin rec_ready = 1'b0; stall++; end
                 else rec_ready = 1'b1;
        default: rec_ready = 1'b1;
      endcase
      acc = rec_valid && rec_ready;
      prev_stalled = rec_valid && !rec_ready;
      pv = rec_vec;
      pr = rec_resp;
      tick();
      c++;
      if (acc) begin
        msig = misr_step(msig, resp_tab[exp_vec(k)]);
        k++;
        checks++;
        if (vec_count !== (IN_W+1)'(k)) begin
          errors++;
          $display("FAIL %s vec_count: got %0d, required %0d", name, vec_count, k);
        end
      end
    end

    checks++;
    if (done !== 1'b1 || k != NVEC) begin
      errors++;
      $display("FAIL %s completion: done=%b records=%0d after %0d cycles, required done=1 records=%0d", name, done, k, c, NVEC);
    end
    checks++;
    if (signature !== msig || vec_count !== (IN_W+1)'(NVEC) || busy !== 1'b0 || dut_in !== exp_vec(NVEC-1)) begin
      errors++;
      $display("FAIL %s final: sig=%h cnt=%0d busy=%b dut_in=%h, required %h/%0d/0/%h", name, signature, vec_count, busy, dut_in, msig, NVEC, exp_vec(NVEC-1));
    end
    if (mode == 0) begin
      checks++;
      if (c != NVEC * (SETTLE + 2)) begin
        errors++;
        $display("FAIL %s sweep-length: %0d cycles, required %0d", name, c, NVEC * (SETTLE + 2));
      end
    end
    if (use_golden) begin
      checks++;
      if (signature !== golden) begin
        errors++;
        $display("FAIL %s golden-sig: got %h, required %h", name, signature, golden);
      end
    end
    // Frozen in DONE.
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || signature !== msig || vec_count !== (IN_W+1)'(NVEC)) begin
      errors++;
      $display("FAIL %s done-frozen: done=%b sig=%h cnt=%0d", name, done, signature, vec_count);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (dut_in !== '0 || rec_valid !== 1'b0 || rec_vec !== '0 || rec_resp !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || signature !== 16'hFFFF || vec_count !== '0) begin
      errors++;
      $display("FAIL %s: dut_in=%h valid=%b vec=%h resp=%h busy=%b done=%b sig=%h cnt=%0d, required all zero with sig FFFF",
               name, dut_in, rec_valid, rec_vec, rec_resp, busy, done, signature, vec_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rec_ready = 1'b0;
    fill_xor();
    #12;
    check_reset_values("reset");
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("idle-after-reset");
  endtask

  task automatic test_xor_sweep();
    fill_xor();
    run_sweep("xor", 0, -1, GOLD_XOR, 1'b1);
  endtask

  task automatic test_zero_resp();
    for (int v = 0; v < NVEC; v++) resp_tab[v] = '0;
    run_sweep("zero", 0, -1, GOLD_ZERO, 1'b1);
  endtask

  task automatic test_backpressure();
    fill_xor();
    run_sweep("stall", 2, -1, GOLD_XOR, 1'b1);
  endtask

  task automatic test_abort();
    fill_xor();
    run_sweep("abort", 0, 2, GOLD_ABORT, 1'b1);
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || signature !== GOLD_ABORT) begin
      errors++;
      $display("FAIL abort-idle: busy=%b done=%b sig=%h, required 0/0/%h", busy, done, signature, GOLD_ABORT);
    end
    run_sweep("restart", 0, -1, GOLD_XOR, 1'b1);
  endtask

  task automatic test_reset_mid();
    fill_xor();
    start = 1'b1;
    rec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("reset-mid");
    #3;
    reset = 1'b1;
    tick();
    check_reset_values("reset-release");
    run_sweep("post-reset", 0, -1, GOLD_XOR, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < NVEC; v++) resp_tab[v] = OUT_W'($urandom);
      run_sweep("random", 1, -1, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_xor();
    run_sweep("b2b-a", 0, -1, GOLD_XOR, 1'b1);
    run_sweep("b2b-b", 1, -1, GOLD_XOR, 1'b1);
  endtask

  initial begin
    test_reset();
    test_xor_sweep();
    test_zero_resp();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trojan_vector_sweeper.md
Name: trojan_vector_sweeper

Overview:
Parametrised stimulus/response engine for the trojan-detection benchmark flow. It sweeps every input combination of an IN_W-bit combinational/sequential benchmark and waits a programmable settle time. It captures the OUT_W-bit response and streams {vector, response} records over a valid/ready interface, so a logger can apply backpressure. It also compacts all responses into a MISR signature for golden-vs-suspect comparison.

Parameters:
IN_W, 2, benchmark input width (1..16); sweep length is 2^IN_W vectors
OUT_W, 1, benchmark output width (1..MISR_W)
SETTLE_CYC, 1, cycles between applying a vector and capturing the response (1..255)
MISR_W, 16, signature width
MISR_POLY, 16'h002D, feedback polynomial (x^16+x^5+x^3+x^2+1)
MISR_SEED, 16'hFFFF, signature value loaded at start

Ports:
CK  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin sweep; sampled only in IDLE/DONE
abort  in  1  synchronous abort to IDLE; priority over all except reset
dut_in  out  IN_W  vector driven to benchmark
dut_out  in  OUT_W  benchmark response
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_vec  out  IN_W  vector of current record
rec_resp  out  OUT_W  captured response
busy  out  1  high in APPLY/SETTLE/HOLD
done  out  1  high in DONE until next start or abort
signature  out  MISR_W  running MISR value
vec_count  out  IN_W+1  records accepted so far

Behaviour:
- Reset (reset=0, async): state IDLE; dut_in=0, rec_valid=0, rec_vec=0, rec_resp=0, busy=0, done=0, signature=MISR_SEED, vec_count=0.
- States: IDLE, APPLY, SETTLE, HOLD, DONE.
- IDLE/DONE + start=1 -> APPLY. Vector index=0, dut_in=first vector, signature=MISR_SEED, vec_count=0, done=0.
- APPLY (1 cycle) -> SETTLE. Settle counter loaded with SETTLE_CYC.
- SETTLE: counter decrements each cycle; after SETTLE_CYC cycles the next edge registers rec_resp=dut_out and rec_vec=dut_in, sets rec_valid=1 and moves to HOLD.
- HOLD: rec_valid, rec_vec and rec_resp stay stable until rec_valid&rec_ready. On the accepting edge:
  - rec_valid=0 and vec_count++.
  - signature = {signature[MISR_W-2:0],1'b0} ^ (signature[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended rec_resp.
  - If the accepted record was the last vector (index 2^IN_W-1), go to DONE. Otherwise the index increments, dut_in updates on the same edge, and the state goes to APPLY.
- Vector order: binary count 0..2^IN_W-1. The index counter is IN_W+1 bits wide, so wrap at 2^IN_W cannot alias.
- Timing, with start sampled at edge E0 and rec_ready tied high: each vector takes SETTLE_CYC+2 cycles, so the whole sweep takes 2^IN_W*(SETTLE_CYC+2) cycles. Defaults: rec_valid first rises after E2; done rises after E12.
- dut_in holds its value through APPLY, SETTLE and HOLD. It also holds the last vector in DONE.
- start while busy: ignored. start and abort in the same cycle: abort wins, next state IDLE.
- abort: next state IDLE, rec_valid=0, busy=0, done=0. signature and vec_count freeze, so a partial result stays readable.
- DONE: signature and vec_count frozen, busy=0, done=1.
- Reset asserted mid-sweep: immediate return to reset values, no record emitted.

Optional Feature:
SWEEP_LFSR_EN. When defined, the vector order is 0 followed by a maximal Fibonacci LFSR sequence seeded with 1:
- next = {s[IN_W-2:0], s[IN_W-1]^s[tap]}, with the tap table provided for IN_W 2..8 (IN_W=2: tap 0).
- The sequence still covers all 2^IN_W vectors exactly once.
- Used to decorrelate adjacent-vector transitions when exciting trojan triggers.
When undefined, the order is the plain binary count. All handshake, timing and MISR behaviour is identical either way.

Test Plan:
1. Defaults; dut_out = dut_in[0]^dut_in[1] (responses 0,1,1,0); rec_ready=1; pulse start -> records (00,0),(01,1),(10,1),(11,0); signature=16'hFE5D; vec_count=4; done=1 after 12 cycles.
2. Same, dut_out tied 0 -> signature=16'hFE5B. Confirms a single response-bit flip changes the signature.
3. rec_ready low for 5 cycles on record 2 -> rec_valid, rec_vec=01 and rec_resp held stable for all 5 cycles; final signature unchanged (16'hFE5D).
4. abort asserted in HOLD of record 3 together with start -> IDLE, done=0, vec_count=2, signature=16'hFF8A. A later start restarts from vector 00 with the seed reloaded.
5. reset pulsed low mid-SETTLE -> all outputs return to reset values asynchronously; start after release gives the full sweep from scenario 1.
6. SWEEP_LFSR_EN defined, IN_W=2, SETTLE_CYC=3 -> vector order 00,01,11,10; 5 cycles per vector; done after 20 cycles.
